mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles waiting for dmem_ack; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ex_valid  input  1  EX stage presents an instruction this cycle.
REQ-005 ex_mem_rd / ex_mem_wr  input  1 each  load / store request; both set SHALL be treated as a store.
REQ-006 ex_size  input  2  00 byte, 01 half, 10 word; 11 SHALL be treated as word.
REQ-007 ex_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-008 ex_alu  input  32  ALU result / effective byte address.
REQ-009 ex_store_data  input  32  store source, right-aligned.
REQ-010 ex_rd, ex_rt  input  5 each  destination register fields, passed through.
REQ-011 ex_ready  output  1  stage accepts ex_valid this cycle; stall to upstream = !ex_ready.
REQ-012 dmem_req, dmem_we  output  1 each  memory request / write strobe.
REQ-013 dmem_addr  output  32  word address, bits [1:0] forced 0.
REQ-014 dmem_wdata  output  32; dmem_be  output  4  byte lanes, little-endian.
REQ-015 dmem_ack  input  1; dmem_rdata  input  32  valid in the ack cycle.
REQ-016 wb_valid  output  1  one-cycle pulse: result registers below hold a new instruction.
REQ-017 dato_mem, ALU  output  32 each; rd, rt  output  5 each  to MEM_WB.
REQ-018 misalign, bus_err  output  1 each  error flags qualified by wb_valid.

Function
REQ-019 States IDLE and ACCESS; ex_ready SHALL equal (state==IDLE) and be registered-state-derived only.
REQ-020 IDLE, ex_valid, no memory op: capture next edge; wb_valid=1 one cycle later (latency 1), dato_mem=0.
REQ-021 IDLE, ex_valid, memory op aligned: latch address, data, size, rd, rt, ALU; go ACCESS; dmem_req=1 from next cycle.
REQ-022 Alignment: half requires addr[0]=0; word requires addr[1:0]=00; misaligned op SHALL not access memory, completes as REQ-020 with misalign=1, dato_mem=0.
REQ-023 ACCESS: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be held constant until the ack cycle inclusive.
REQ-024 Ack cycle: return to IDLE, dmem_req=0 next cycle, wb_valid=1 next cycle; ex_ready high next cycle.
REQ-025 Store lanes: byte wdata={4{d[7:0]}}, be=0001<<addr[1:0]; half wdata={2{d[15:0]}}, be=addr[1]?1100:0011; word be=1111.
REQ-026 Load extract: byte lane addr[1:0], half lane addr[1], then sign/zero-extend per ex_unsigned; store completion SHALL give dato_mem=0.
REQ-027 Reads SHALL drive dmem_we=0, dmem_be=1111, dmem_wdata=0.
REQ-028 Wait counter cleared on ACCESS entry, increments each non-ack cycle; reaching TIMEOUT SHALL abort: IDLE, wb_valid=1, bus_err=1, dato_mem=0.
REQ-029 Ack coincident with the TIMEOUT cycle SHALL count as success (ack wins).
REQ-030 dmem_ack while IDLE SHALL be ignored.
REQ-031 When wb_valid=0, result outputs SHALL hold last values; flags clear when next wb_valid pulses without error.

Reset
REQ-032 rst=1 at an edge: state IDLE, counter 0, all outputs 0 (ex_ready=1 after the edge).
REQ-033 Reset during ACCESS SHALL drop the transaction: no wb_valid, dmem_req=0 next cycle, late ack ignored.

Verification
REQ-034 ALU op, ex_alu=0x1234, rd=3: wb_valid one cycle later, ALU=0x1234, rd=3, dato_mem=0.
REQ-035 Load byte signed addr 0x103, rdata=0x80FF_0011, ack after 3 cycles: dato_mem=0xFFFF_FF80, ex_ready low 4 cycles.
REQ-036 Store half addr 0x202, data 0xABCD: dmem_addr=0x200, be=1100, wdata=0xABCD_ABCD, we=1.
REQ-037 Load word addr 0x0006: no dmem_req, wb_valid next cycle, misalign=1.
REQ-038 TIMEOUT=4, no ack: bus_err=1 with wb_valid after 4 wait cycles; repeat with ack on cycle 4 -> bus_err=0.
REQ-039 rst asserted in second ACCESS cycle, ack one cycle later: no wb_valid, dmem_req=0, ex_ready=1.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
// The read data is only meaningful in the cycle where the ack is high.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory access per instruction, aligns store lanes,
// extracts and extends load data, and hands a one-cycle result pulse to MEM/WB.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    input  logic                     ex_mem_rd,
    input  logic                     ex_mem_wr,
    input  logic [1:0]               ex_size,
    input  logic                     ex_unsigned,
    input  logic [31:0]              ex_alu,
    input  logic [31:0]              ex_store_data,
    input  logic [4:0]               ex_rd,
    input  logic [4:0]               ex_rt,
    output logic                     ex_ready,
    mem_access_stage_if.master       dmem,
    output logic                     wb_valid,
    output logic [31:0]              dato_mem,
    output logic [31:0]              ALU,
    output logic [4:0]               rd,
    output logic [4:0]               rt,
    output logic                     misalign,
    output logic                     bus_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    // With TIMEOUT of zero this value is never compared against.
    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT) - 32'd1;

    state_t      state, next_state;
    logic [31:0] wait_cnt;

    logic        mem_op;
    logic [1:0]  eff_size;
    logic        misaligned_req;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;

    logic        accept_alu, accept_mem, done_ok, done_err;

    logic [31:0] pend_alu;
    logic [4:0]  pend_rd, pend_rt;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        uns_q;
    logic        store_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;

    assign ex_ready        = (state == IDLE);
    assign dmem.dmem_req   = (state == ACCESS);
    assign dmem.dmem_we    = (state == ACCESS) && store_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    // Request decode: size 11 behaves as a word, a store wins over a load.
    always_comb begin
        mem_op         = ex_mem_rd || ex_mem_wr;
        eff_size       = (ex_size == 2'b11) ? 2'b10 : ex_size;
        misaligned_req = 1'b0;
        st_wdata       = 32'd0;
        st_be          = 4'b1111;
        case (eff_size)
            2'b01:   misaligned_req = mem_op && ex_alu[0];
            2'b10:   misaligned_req = mem_op && (ex_alu[1:0] != 2'b00);
            default: misaligned_req = 1'b0;
        endcase
        if (ex_mem_wr) begin
            case (eff_size)
                2'b00: begin
                    st_wdata = {4{ex_store_data[7:0]}};
                    st_be    = 4'b0001 << ex_alu[1:0];
                end
                2'b01: begin
                    st_wdata = {2{ex_store_data[15:0]}};
                    st_be    = ex_alu[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    st_wdata = ex_store_data;
                    st_be    = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ack is checked before the timeout so a late-but-in-time ack still succeeds.
    always_comb begin
        next_state = state;
        accept_alu = 1'b0;
        accept_mem = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (mem_op && !misaligned_req) begin
                        accept_mem = 1'b1;
                        next_state = ACCESS;
                    end else begin
                        accept_alu = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (dmem.dmem_ack) begin
                    done_ok    = 1'b1;
                    next_state = IDLE;
                end else if (TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                    done_err   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_byte = 8'd0;
        load_half = 16'd0;
        load_val  = dmem.dmem_rdata;
        case (lane_q)
            2'b00:   load_byte = dmem.dmem_rdata[7:0];
            2'b01:   load_byte = dmem.dmem_rdata[15:8];
            2'b10:   load_byte = dmem.dmem_rdata[23:16];
            default: load_byte = dmem.dmem_rdata[31:24];
        endcase
        load_half = lane_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (size_q)
            2'b00:   load_val = uns_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
            2'b01:   load_val = uns_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
            default: load_val = dmem.dmem_rdata;
        endcase
    end

    // Result registers only change together with a wb_valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 32'd0;
            wb_valid <= 1'b0;
            dato_mem <= 32'd0;
            ALU      <= 32'd0;
            rd       <= 5'd0;
            rt       <= 5'd0;
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            pend_alu <= 32'd0;
            pend_rd  <= 5'd0;
            pend_rt  <= 5'd0;
            size_q   <= 2'b00;
            lane_q   <= 2'b00;
            uns_q    <= 1'b0;
            store_q  <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
        end else begin
            wb_valid <= 1'b0;
            if (accept_alu) begin
                wb_valid <= 1'b1;
                dato_mem <= 32'd0;
                ALU      <= ex_alu;
                rd       <= ex_rd;
                rt       <= ex_rt;
                misalign <= misaligned_req;
                bus_err  <= 1'b0;
            end
            if (accept_mem) begin
                wait_cnt <= 32'd0;
                pend_alu <= ex_alu;
                pend_rd  <= ex_rd;
                pend_rt  <= ex_rt;
                size_q   <= eff_size;
                lane_q   <= ex_alu[1:0];
                uns_q    <= ex_unsigned;
                store_q  <= ex_mem_wr;
                addr_q   <= {ex_alu[31:2], 2'b00};
                wdata_q  <= st_wdata;
                be_q     <= st_be;
            end
            if (state == ACCESS && !dmem.dmem_ack && !done_err) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (done_ok || done_err) begin
                wb_valid <= 1'b1;
                dato_mem <= (done_ok && !store_q) ? load_val : 32'd0;
                ALU      <= pend_alu;
                rd       <= pend_rd;
                rt       <= pend_rt;
                misalign <= 1'b0;
                bus_err  <= done_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: the bench plays the data memory and predicts each
// result from byte-lane arithmetic rather than from the stage's own structure.
module tb_mem_access_stage;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_unsigned;
    logic [1:0]  ex_size;
    logic [31:0] ex_alu, ex_store_data;
    logic [4:0]  ex_rd, ex_rt;
    logic        ex_ready;
    logic        wb_valid, misalign, bus_err;
    logic [31:0] dato_mem, ALU;
    logic [4:0]  rd, rt;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] lastDato, lastAlu;
    logic [4:0]  lastRd, lastRt;

    mem_access_stage_if dmem ();

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_alu(ex_alu),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_rt(ex_rt),
        .ex_ready(ex_ready), .dmem(dmem),
        .wb_valid(wb_valid), .dato_mem(dato_mem), .ALU(ALU), .rd(rd), .rt(rt),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic checkWb(input logic [31:0] expDato, input logic [31:0] expAlu, input logic [4:0] expRd,
                           input logic [4:0] expRt, input logic expMis, input logic expErr);
        checkOutput("wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("dato_mem", dato_mem, expDato);
        checkOutput("ALU", ALU, expAlu);
        checkOutput("rd", 32'(rd), 32'(expRd));
        checkOutput("rt", 32'(rt), 32'(expRt));
        checkOutput("misalign", 32'(misalign), 32'(expMis));
        checkOutput("bus_err", 32'(bus_err), 32'(expErr));
        lastDato = expDato;
        lastAlu  = expAlu;
        lastRd   = expRd;
        lastRt   = expRt;
    endtask

    // One instruction through the stage; ackDelay counts request cycles without ack before the ack.
    task automatic applyStimulus(input logic rdOp, input logic wrOp, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rdF,
                                 input logic [4:0] rtF, input logic [31:0] rdata, input int ackDelay);
        longint unsigned nBytes, offset, mask, rep, loadVal, expBe, expWdata;
        logic memOp, isStore, misal, timedOut, acked;
        logic [31:0] expDato;

        memOp    = rdOp | wrOp;
        isStore  = wrOp;
        nBytes   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        offset   = longint'(addr) % 4;
        misal    = memOp && ((longint'(addr) % nBytes) != 0);
        mask     = (64'd1 << (8 * nBytes)) - 1;
        rep      = (nBytes == 1) ? 64'h0101_0101 : (nBytes == 2) ? 64'h0001_0001 : 64'd1;
        expBe    = isStore ? (((64'd1 << nBytes) - 1) << offset) : 64'd15;
        expWdata = isStore ? ((longint'(data) & mask) * rep) : 64'd0;
        loadVal  = (longint'(rdata) >> (8 * offset)) & mask;
        if (!uns && nBytes < 4 && loadVal >= (mask + 1) / 2) begin
            loadVal = loadVal + 64'h1_0000_0000 - (mask + 1);
        end
        timedOut = (ackDelay >= int'(TIMEOUT));
        expDato  = (isStore || timedOut) ? 32'd0 : 32'(loadVal);

        @(negedge clk);
        checkOutput("hold_wb_quiet", 32'(wb_valid), 32'd0);
        checkOutput("hold_ALU", ALU, lastAlu);
        checkOutput("hold_dato", dato_mem, lastDato);
        checkOutput("ready_idle", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_mem_rd = rdOp; ex_mem_wr = wrOp; ex_size = size; ex_unsigned = uns;
        ex_alu = addr; ex_store_data = data; ex_rd = rdF; ex_rt = rtF;
        @(negedge clk);
        ex_valid = 1'b0;
        ex_mem_rd = 1'($urandom); ex_mem_wr = 1'($urandom); ex_alu = $urandom; ex_store_data = $urandom;

        if (!memOp || misal) begin
            checkOutput("no_req", 32'(dmem.dmem_req), 32'd0);
            checkWb(32'd0, addr, rdF, rtF, misal, 1'b0);
        end else begin
            acked = 1'b0;
            for (int k = 1; k <= int'(TIMEOUT) && !acked; k++) begin
                checkOutput("req_high", 32'(dmem.dmem_req), 32'd1);
                checkOutput("ready_low", 32'(ex_ready), 32'd0);
                checkOutput("wb_wait", 32'(wb_valid), 32'd0);
                checkOutput("dmem_addr", dmem.dmem_addr, addr - 32'(offset));
                checkOutput("dmem_we", 32'(dmem.dmem_we), 32'(isStore));
                checkOutput("dmem_be", 32'(dmem.dmem_be), 32'(expBe));
                checkOutput("dmem_wdata", dmem.dmem_wdata, 32'(expWdata));
                if (ackDelay == k - 1) begin
                    dmem.dmem_ack   = 1'b1;
                    dmem.dmem_rdata = rdata;
                    acked = 1'b1;
                end
                @(negedge clk);
                dmem.dmem_ack   = 1'b0;
                dmem.dmem_rdata = $urandom;
            end
            checkOutput("req_drop", 32'(dmem.dmem_req), 32'd0);
            checkOutput("ready_back", 32'(ex_ready), 32'd1);
            checkWb(expDato, addr, rdF, rtF, 1'b0, timedOut);
        end
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
        ex_alu = 32'd0; ex_store_data = 32'd0; ex_rd = 5'd0; ex_rt = 5'd0;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'd0;
        lastDato = 32'd0; lastAlu = 32'd0; lastRd = 5'd0; lastRt = 5'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(ex_ready), 32'd1);
        checkOutput("rst_req", 32'(dmem.dmem_req), 32'd0);
        checkOutput("rst_be", 32'(dmem.dmem_be), 32'd0);
        checkOutput("rst_wb", 32'(wb_valid), 32'd0);
        checkOutput("rst_ALU", ALU, 32'd0);
        checkOutput("rst_dato", dato_mem, 32'd0);
        checkOutput("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
        rst = 1'b0;

        $display("[TB] directed cases");
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_1234, 32'd0, 5'd3, 5'd7, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 5'd4, 5'd5, 32'h80FF_0011, 3);
        checkOutput("byte_signed_const", dato_mem, 32'hFFFF_FF80);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd6, 5'd8, 32'd0, 1);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0, 5'd9, 5'd10, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'd0, 5'd11, 5'd12, 32'h1234_5678, 9);
        applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'd0, 5'd13, 5'd14, 32'hCAFE_F00D, 3);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b1, 32'h0000_0088, 32'h0BAD_BEEF, 5'd15, 5'd16, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'd0, 5'd17, 5'd18, 32'h8765_4321, 2);

        $display("[TB] ack while idle");
        @(negedge clk);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem.dmem_ack = 1'b0;
        checkOutput("idle_ack_wb", 32'(wb_valid), 32'd0);
        checkOutput("idle_ack_req", 32'(dmem.dmem_req), 32'd0);
        checkOutput("idle_ack_ready", 32'(ex_ready), 32'd1);

        $display("[TB] reset during access");
        @(negedge clk);
        ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0; ex_size = 2'd2; ex_alu = 32'h0000_0040;
        @(negedge clk);
        ex_valid = 1'b0;
        checkOutput("rst_acc_req1", 32'(dmem.dmem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_acc_req", 32'(dmem.dmem_req), 32'd0);
        checkOutput("rst_acc_ready", 32'(ex_ready), 32'd1);
        checkOutput("rst_acc_wb", 32'(wb_valid), 32'd0);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        dmem.dmem_ack = 1'b0;
        checkOutput("late_ack_wb", 32'(wb_valid), 32'd0);
        checkOutput("late_ack_req", 32'(dmem.dmem_req), 32'd0);
        checkOutput("late_ack_ALU", ALU, 32'd0);
        lastDato = 32'd0; lastAlu = 32'd0; lastRd = 5'd0; lastRt = 5'd0;

        $display("[TB] random cases");
        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            applyStimulus(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                          5'($urandom), 5'($urandom), $urandom, int'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
